// File: rtl/user_obi_copy_dma.sv
// Word-by-word OBI copy engine: read one word from src, write it to dst, repeat len times.
// Optional macro USER_OBI_DMA_ERR_ABORT_EN: an error response ends the transfer at once.
package croc_pkg;
  localparam int unsigned AidWidth = 1;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

module user_obi_copy_dma
  import croc_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned OBI_AID   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 dst_incr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output mgr_obi_req_t         obi_req_o,
  input  mgr_obi_rsp_t         obi_rsp_i
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_e;

  localparam logic [AidWidth-1:0] Aid = AidWidth'(OBI_AID);

  state_e                state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [31:0]           data_q, data_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  incr_q, incr_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_q, req_d;
  mgr_obi_a_chan_t       a_q, a_d;

  logic unused_rid;
  assign unused_rid = ^obi_rsp_i.r.rid;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    count_d = count_q;
    incr_d  = incr_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i != '0) begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            count_d = len_i;
            incr_d  = dst_incr_i;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_REQ: if (obi_rsp_i.gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          data_d  = obi_rsp_i.r.rdata;
          err_d   = err_q | obi_rsp_i.r.err;
          state_d = WR_REQ;
`ifdef USER_OBI_DMA_ERR_ABORT_EN
          if (obi_rsp_i.r.err) state_d = DONE;
`endif
        end
      end
      WR_REQ: if (obi_rsp_i.gnt) state_d = WR_WAIT;
      WR_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          err_d   = err_q | obi_rsp_i.r.err;
          count_d = count_q - LEN_WIDTH'(1);
          src_d   = src_q + 32'd4;
          if (incr_q) dst_d = dst_q + 32'd4;
          state_d = (count_q == LEN_WIDTH'(1)) ? DONE : RD_REQ;
`ifdef USER_OBI_DMA_ERR_ABORT_EN
          if (obi_rsp_i.r.err) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    req_d = 1'b0;
    a_d   = '0;
    if (state_d == RD_REQ) begin
      req_d   = 1'b1;
      a_d.addr = src_d;
      a_d.be   = 4'hF;
      a_d.aid  = Aid;
    end else if (state_d == WR_REQ) begin
      req_d    = 1'b1;
      a_d.addr  = dst_d;
      a_d.we    = 1'b1;
      a_d.be    = 4'hF;
      a_d.wdata = data_d;
      a_d.aid   = Aid;
    end
    busy_d = (state_d inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT});
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      count_q <= count_d;
      incr_q  <= incr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      a_q     <= a_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign obi_req_o.req = req_q;
  assign obi_req_o.a   = a_q;

endmodule

// File: tb/tb_user_obi_copy_dma.sv
// Bench for user_obi_copy_dma: OBI memory responder, transaction log and a word-list reference model.
module tb_user_obi_copy_dma;
  import croc_pkg::*;

  localparam int LW = 16;
`ifdef USER_OBI_DMA_ERR_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } txn_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   src_addr_i, dst_addr_i;
  logic [LW-1:0] len_i;
  logic          dst_incr_i;
  logic          busy_o, done_o, err_o;
  mgr_obi_req_t  obi_req;
  mgr_obi_rsp_t  obi_rsp;

  int checks = 0;
  int errors = 0;

  // Memory-side knobs (written by the main sequence only)
  int stall_read_num = 0;
  int stall_len      = 0;
  int max_rand_stall = 0;
  bit spurious_en    = 1'b0;
  int err_read_num   = 0;

  // Memory-side observations (written by the responder/monitor only)
  txn_t log_q[$];
  int   reads_total  = 0;
  int   stall_cycles = 0;
  int   stab_bad     = 0;
  int   drop_bad     = 0;
  int   done_cnt     = 0;
  int   busy_cnt     = 0;

  always #5 clk_i = ~clk_i;

  user_obi_copy_dma #(.LEN_WIDTH(LW), .OBI_AID(0)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .dst_incr_i (dst_incr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // OBI responder: decides gnt on the falling edge, returns rvalid one cycle after gnt.
  initial begin
    bit              pend = 1'b0;
    bit              pend_err = 1'b0;
    logic [31:0]     pend_rdata = '0;
    bit              in_stall = 1'b0;
    int              stall_left = 0;
    mgr_obi_a_chan_t held_a = '0;
    txn_t            t;
    obi_rsp = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        obi_rsp  = '0;
        pend     = 1'b0;
        in_stall = 1'b0;
      end else begin
        if (pend) begin
          obi_rsp.rvalid  = 1'b1;
          obi_rsp.r.err   = pend_err;
          obi_rsp.r.rdata = pend_rdata;
        end else begin
          obi_rsp.rvalid  = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
          obi_rsp.r.err   = obi_rsp.rvalid;
          obi_rsp.r.rdata = $urandom;
        end
        pend        = 1'b0;
        obi_rsp.gnt = 1'b0;
        if (in_stall && !obi_req.req) begin
          drop_bad++;
          in_stall = 1'b0;
        end
        if (obi_req.req) begin
          if (!in_stall) begin
            in_stall = 1'b1;
            held_a   = obi_req.a;
            if (!obi_req.a.we && (reads_total + 1 == stall_read_num)) stall_left = stall_len;
            else if (max_rand_stall > 0) stall_left = int'($urandom_range(0, max_rand_stall));
            else stall_left = 0;
          end else if (obi_req.a !== held_a) begin
            stab_bad++;
          end
          if (stall_left == 0) begin
            obi_rsp.gnt = 1'b1;
            in_stall    = 1'b0;
            t = '{addr: obi_req.a.addr, we: obi_req.a.we, be: obi_req.a.be,
                  wdata: obi_req.a.wdata, aid: obi_req.a.aid};
            log_q.push_back(t);
            if (!obi_req.a.we) begin
              reads_total++;
              pend_rdata = mem_word(obi_req.a.addr);
              pend_err   = (reads_total == err_read_num);
            end else begin
              pend_rdata = $urandom;
              pend_err   = 1'b0;
            end
            pend = 1'b1;
          end else begin
            stall_left--;
            stall_cycles++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input logic [LW-1:0] l, input logic inc);
    @(negedge clk_i);
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = l;
    dst_incr_i = inc;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    src_addr_i = $urandom;
    dst_addr_i = $urandom;
    len_i      = LW'($urandom);
    dst_incr_i = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_o !== 1'b1 && n < 400) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk(tag, done_o, 1);
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Expected bus traffic: read src+4i, then write that word to dst (+4i when incrementing).
  task automatic verify(input string tag, input int n0, input logic [31:0] s, input logic [31:0] d,
                        input int l, input logic inc, input int err_idx);
    txn_t exp_q[$];
    txn_t e;
    for (int i = 0; i < l; i++) begin
      e = '{addr: s + 32'(4 * i), we: 1'b0, be: 4'hF, wdata: 32'h0, aid: '0};
      exp_q.push_back(e);
      if (AbortEn && i == err_idx) break;
      e = '{addr: inc ? d + 32'(4 * i) : d, we: 1'b1, be: 4'hF,
            wdata: mem_word(s + 32'(4 * i)), aid: '0};
      exp_q.push_back(e);
    end
    chk({tag, "_ntxn"}, 80'(log_q.size() - n0), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (n0 + i < log_q.size()) chk({tag, "_txn"}, log_q[n0 + i], exp_q[i]);
  endtask

  task automatic run(input string tag, input logic [31:0] s, input logic [31:0] d, input int l,
                     input logic inc, input int err_idx, input logic exp_err);
    int n0 = log_q.size();
    int d0 = done_cnt;
    start_xfer(s, d, LW'(l), inc);
    wait_done({tag, "_done"});
    settle();
    chk({tag, "_done_once"}, 80'(done_cnt - d0), 80'd1);
    chk({tag, "_err"}, err_o, exp_err);
    verify(tag, n0, s, d, l, inc, err_idx);
  endtask

  initial begin
    int n0, d0, b0, sc0, n;
    logic [31:0] s, d;
    rst_ni = 1'b0;
    start_i = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i = '0;
    dst_incr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", obi_req.req, 0);
    chk("rst_a", obi_req.a, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic three-word copy with zero-wait memory
    b0 = busy_cnt;
    run("basic", 32'h1000, 32'h2000, 3, 1'b1, -1, 1'b0);
    chk("basic_busy_cycles", 80'(busy_cnt - b0), 80'd12);

    run("fixed_dst", 32'h0000_4000, 32'h3000_0004, 2, 1'b0, -1, 1'b0);

    // First read grant withheld for five cycles
    stall_read_num = reads_total + 1;
    stall_len = 5;
    sc0 = stall_cycles;
    run("stall", 32'h0000_5000, 32'h0000_6000, 1, 1'b1, -1, 1'b0);
    chk("stall_cycles", 80'(stall_cycles - sc0), 80'd5);
    chk("stall_stable", 80'(stab_bad), 80'd0);
    chk("stall_no_drop", 80'(drop_bad), 80'd0);
    stall_len = 0;

    // Zero-length start: straight to DONE, no bus traffic
    n0 = log_q.size();
    d0 = done_cnt;
    start_xfer(32'h7000, 32'h8000, '0, 1'b1);
    chk("len0_done", done_o, 1);
    chk("len0_busy", busy_o, 0);
    settle();
    chk("len0_ntxn", 80'(log_q.size() - n0), 80'd0);
    chk("len0_done_once", 80'(done_cnt - d0), 80'd1);
    chk("len0_err", err_o, 0);

    // Error response on the second read of four
    err_read_num = reads_total + 2;
    run("rderr", 32'h0000_9000, 32'h0000_A000, 4, 1'b1, 1, 1'b1);
    err_read_num = 0;
    start_xfer(32'h0, 32'h0, '0, 1'b0);
    settle();
    chk("err_cleared", err_o, 0);

    // Reset while waiting for a write response
    n0 = log_q.size();
    start_xfer(32'h0000_B000, 32'h0000_C000, LW'(4), 1'b1);
    n = 0;
    while (log_q.size() < n0 + 2 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("rst_reach_wr", 80'(log_q.size() >= n0 + 2), 80'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", obi_req.req, 0);
    chk("midrst_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    n0 = log_q.size();
    d0 = done_cnt;
    start_xfer(32'h0000_D000, 32'h0000_E000, LW'(3), 1'b0);
    @(negedge clk_i);
    src_addr_i = 32'h0000_F000;
    dst_addr_i = 32'h0001_0000;
    len_i = LW'(7);
    dst_incr_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("restart_done");
    settle();
    chk("restart_done_once", 80'(done_cnt - d0), 80'd1);
    verify("restart", n0, 32'h0000_D000, 32'h0000_E000, 3, 1'b0, -1);

    // Address wrap past 2^32
    run("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b1, -1, 1'b0);

    // Random transfers with random grant stalls and stray rvalids outside the wait states
    max_rand_stall = 3;
    spurious_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = {$urandom, 2'b00} & 32'h0FFF_FFFC;
      d = ({$urandom, 2'b00} & 32'h0FFF_FFFC) | 32'h8000_0000;
      run("rand", s, d, int'($urandom_range(1, 6)), 1'($urandom), -1, 1'b0);
    end
    spurious_en = 1'b0;
    chk("final_stable", 80'(stab_bad), 80'd0);
    chk("final_no_drop", 80'(drop_bad), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
